clock_supervisor: RTL and testbench
===================================

Name: clock_supervisor

Overview:
- Parametrised clock-manager stage that sits directly after the PLL wrapper, in the PLL output clock domain.
- Synchronises and filters the raw PLL lock flag and sequences the system reset.
- Generates NUM_CE clock-enable strobes with runtime-adjustable divide ratios.
- Counts lock-loss events for debug, so downstream logic (6502 core, UART, peripherals) gets one clean reset and derived enables instead of extra PLLs.

Parameters:
- SYNC_STAGES, 2: flops in the locked_in synchroniser; minimum 2.
- LOCK_FILTER, 1024: consecutive synchronised-lock cycles required before reset sequencing starts; minimum 1.
- RESET_HOLD, 16: cycles rst_out_n stays low after the filter passes; minimum 1.
- NUM_CE, 2: number of clock-enable channels; 1..8.
- DIV_W, 16: width of each divide ratio.
- CE_DIVS, {16'd50,16'd5}: packed NUM_CE*DIV_W reset-default divide ratios; channel 0 in the LSBs.

Ports:
- clock_in  in  1  PLL output clock; the only clock of the block.
- resetn  in  1  asynchronous, active-low reset.
- locked_in  in  1  raw PLL lock flag; asynchronous to clock_in.
- div_wr  in  1  one-cycle strobe that writes div_val to channel div_sel.
- div_sel  in  max(1,$clog2(NUM_CE))  target channel.
- div_val  in  DIV_W  new divide ratio.
- lock_loss_clr  in  1  clears lock_loss_count.
- rst_out_n  out  1  system reset, active low, registered.
- ready  out  1  high only in RUN, registered.
- ce  out  NUM_CE  clock-enable strobes, registered.
- lock_loss_count  out  8  saturating lock-loss event count.

Behaviour:
Reset and synchroniser
- resetn low: all flops cleared immediately. State = WAIT_LOCK, rst_out_n=0, ready=0, ce=0, lock_loss_count=0, active dividers = CE_DIVS.
- locked_in passes through the SYNC_STAGES synchroniser (reset to 0), giving lock_s. All decisions use lock_s only.

State machine (2-bit)
- WAIT_LOCK: filter counter = 0. lock_s=1 -> FILTER.
- FILTER: counter increments each cycle.
  - lock_s=0 -> WAIT_LOCK, counter cleared.
  - counter reaches LOCK_FILTER-1 with lock_s=1 -> HOLD.
- HOLD: hold counter increments.
  - lock_s=0 -> WAIT_LOCK; no loss counted.
  - counter reaches RESET_HOLD-1 -> RUN.
- RUN: rst_out_n=1, ready=1.
  - lock_s=0 -> WAIT_LOCK; rst_out_n=0, ready=0 and ce=0 from the next cycle.
  - lock_loss_count increments, saturating at 255.
- Latency from locked_in rising (stable) to rst_out_n=1: SYNC_STAGES + LOCK_FILTER + RESET_HOLD + 1 cycles, exact.
- rst_out_n and ready are always equal.

Clock enables
- Per channel: counter cnt_i, cleared whenever state != RUN.
- In RUN: ce[i]=1 in the first RUN cycle, then every DIV_i cycles; cnt_i wraps at DIV_i-1.
- DIV_i of 0 or 1: ce[i] is constant 1 in RUN.
- Each ce pulse is exactly one cycle wide for DIV_i >= 2. No runt pulses.

Divider writes
- div_wr in RUN: value goes to a per-channel shadow register. It becomes active at that channel's next wrap, i.e. the cycle after the next ce[i] pulse. The current period always completes with the old ratio.
- div_wr outside RUN: takes effect immediately.
- Repeated writes before the wrap: last write wins.
- div_sel >= NUM_CE: write ignored.
- resetn restores CE_DIVS. Lock loss does not; written ratios persist.

Lock-loss counter
- lock_loss_clr alone: count = 0 next cycle.
- lock_loss_clr coincident with a loss event: count = 1; the event is recorded.

Decomposition:
- Package clock_supervisor_pkg: state encoding (WAIT_LOCK=0, FILTER=1, HOLD=2, RUN=3), DIV_W default, LOSS_CNT_W=8, and a function for the filter/hold counter width, $clog2(max(LOCK_FILTER,RESET_HOLD)+1).
- Sub-module ce_divider: one channel holding cnt, active ratio, shadow ratio and the ce register. Inputs are run, wr, val. Instantiated NUM_CE times in a generate loop.
- The top holds the synchroniser, FSM, counters and loss counter.

Test Plan:
- LOCK_FILTER=8, RESET_HOLD=4, SYNC_STAGES=2; release resetn, raise locked_in at cycle 10 -> rst_out_n and ready rise at cycle 10+2+8+4+1=25; ce[0] first pulse at cycle 25.
- Glitch during filter: locked_in high 5 cycles, low 1, high again -> filter restarts; rst_out_n rises 15 cycles after the second rise; lock_loss_count stays 0.
- CE_DIVS={50,5} in RUN -> ce[0] every 5 cycles, ce[1] every 50; write div_sel=0, div_val=3 mid-period -> the current 5-cycle period completes, then the 3-cycle period; div_val=0 -> ce[0] constant 1.
- Drop locked_in in RUN -> rst_out_n=0, ready=0, ce=0 after SYNC_STAGES+1 cycles; count=1; 300 loss events -> count saturates at 255; lock_loss_clr coincident with a loss -> count=1.
- Assert resetn low mid-HOLD and mid-RUN -> all outputs at reset values asynchronously; a previously written divide ratio reverts to CE_DIVS; div_sel=3 with NUM_CE=2 -> no channel changes.

Source files
------------

// File: rtl/clock_supervisor_pkg.sv
// Clock supervisor shared definitions.
// State encoding, widths and counter sizing helper.
package clock_supervisor_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int DIV_W_DEF  = 16;
    localparam int LOSS_CNT_W = 8;

    // Width of the shared filter/hold counter.
    function automatic int cnt_width(input int lock_filter, input int reset_hold);
        int m;
        m = (lock_filter > reset_hold) ? lock_filter : reset_hold;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clock_supervisor_ce.sv
// One clock-enable channel: period counter, active and shadow ratio.
// Ratio changes in RUN wait for the current period to finish.
module ce_divider
    import clock_supervisor_pkg::*;
#(
    parameter int               DIV_W   = DIV_W_DEF,
    parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] val_i,
    output logic             ce_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] shd_q, shd_d;
    logic             ce_q, ce_d;
    logic             flat;
    logic             wrap;

    assign flat = (div_q < DIV_W'(2));
    assign wrap = flat || (cnt_q == (div_q - DIV_W'(1)));

    // Period counting, pulse generation and wrap-aligned ratio reload.
    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        shd_d = shd_q;
        ce_d  = 1'b0;
        if (!run_i) begin
            cnt_d = '0;
            if (wr_i) begin
                div_d = val_i;
                shd_d = val_i;
            end
        end else begin
            ce_d = (cnt_q == '0) || flat;
            if (wr_i) begin
                shd_d = val_i;
            end
            if (wrap) begin
                cnt_d = '0;
                div_d = wr_i ? val_i : shd_q;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            div_q <= RST_DIV;
            shd_q <= RST_DIV;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
            shd_q <= shd_d;
            ce_q  <= ce_d;
        end
    end

    assign ce_o = ce_q;

endmodule

// File: rtl/clock_supervisor.sv
// Lock synchroniser/filter, reset sequencer, loss counter
// and a bank of programmable clock-enable channels.
module clock_supervisor
    import clock_supervisor_pkg::*;
#(
    parameter int                        SYNC_STAGES = 2,
    parameter int                        LOCK_FILTER = 1024,
    parameter int                        RESET_HOLD  = 16,
    parameter int                        NUM_CE      = 2,
    parameter int                        DIV_W       = DIV_W_DEF,
    parameter logic [NUM_CE*DIV_W-1:0]   CE_DIVS     = {16'd50, 16'd5},
    localparam int                       SEL_W       = (NUM_CE > 1) ? $clog2(NUM_CE) : 1
) (
    input  logic                  clock_in,
    input  logic                  resetn,
    input  logic                  locked_in,
    input  logic                  div_wr,
    input  logic [SEL_W-1:0]      div_sel,
    input  logic [DIV_W-1:0]      div_val,
    input  logic                  lock_loss_clr,
    output logic                  rst_out_n,
    output logic                  ready,
    output logic [NUM_CE-1:0]     ce,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    localparam int CNT_W = cnt_width(LOCK_FILTER, RESET_HOLD);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   run;
    logic                   loss;
    logic                   rst_q;
    logic [LOSS_CNT_W-1:0]  loss_q, loss_d;

    // Bring the asynchronous lock flag into the clock domain.
    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked_in};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];
    assign run    = (state_q == RUN);
    assign loss   = run && !lock_s;

    // Lock filter and reset hold sequencing on one shared counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = FILTER;
                end
            end
            FILTER: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CNT_W'(LOCK_FILTER - 1)) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CNT_W'(RESET_HOLD - 1)) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    // Saturating loss count; a clear never hides a coincident event.
    always_comb begin
        loss_d = loss_q;
        if (lock_loss_clr) begin
            loss_d = loss ? LOSS_CNT_W'(1) : '0;
        end else if (loss && (loss_q != '1)) begin
            loss_d = loss_q + LOSS_CNT_W'(1);
        end
    end

    // Sequencer, loss counter and registered reset output.
    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            loss_q  <= '0;
            rst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            loss_q  <= loss_d;
            rst_q   <= run;
        end
    end

    assign rst_out_n       = rst_q;
    assign ready           = rst_q;
    assign lock_loss_count = loss_q;

    for (genvar g = 0; g < NUM_CE; g++) begin : g_ce
        ce_divider #(
            .DIV_W   (DIV_W),
            .RST_DIV (CE_DIVS[g*DIV_W +: DIV_W])
        ) u_div (
            .clk_i  (clock_in),
            .rst_ni (resetn),
            .run_i  (run),
            .wr_i   (div_wr && (div_sel == SEL_W'(g))),
            .val_i  (div_val),
            .ce_o   (ce[g])
        );
    end

endmodule

// File: tb/tb_clock_supervisor.sv
// Directed bench for clock_supervisor.
// Short filter/hold and three channels (5, 50, 7).
module tb_clock_supervisor;

    logic        clk;
    logic        resetn;
    logic        locked_in;
    logic        div_wr;
    logic [1:0]  div_sel;
    logic [15:0] div_val;
    logic        lock_loss_clr;
    logic        rst_out_n;
    logic        ready;
    logic [2:0]  ce;
    logic [7:0]  lock_loss_count;

    int n_tests = 0;
    int n_fail  = 0;

    clock_supervisor #(
        .SYNC_STAGES (2),
        .LOCK_FILTER (8),
        .RESET_HOLD  (4),
        .NUM_CE      (3),
        .DIV_W       (16),
        .CE_DIVS     ({16'd7, 16'd50, 16'd5})
    ) dut (
        .clock_in        (clk),
        .resetn          (resetn),
        .locked_in       (locked_in),
        .div_wr          (div_wr),
        .div_sel         (div_sel),
        .div_val         (div_val),
        .lock_loss_clr   (lock_loss_clr),
        .rst_out_n       (rst_out_n),
        .ready           (ready),
        .ce              (ce),
        .lock_loss_count (lock_loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lock sampled at the next edge, reset released 15 edges later
    task automatic relock();
        locked_in = 1'b1;
        repeat (15) tick();
        check("relock_early", 32'(rst_out_n), 32'd0);
        tick();
        check("relock_rst", 32'(rst_out_n), 32'd1);
    endtask

    task automatic drop_lock();
        locked_in = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        resetn        = 1'b0;
        locked_in     = 1'b0;
        div_wr        = 1'b0;
        div_sel       = 2'd0;
        div_val       = 16'd0;
        lock_loss_clr = 1'b0;
        #2;
        check("rst_rstn", 32'(rst_out_n), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_ce", 32'(ce), 32'd0);
        check("rst_cnt", 32'(lock_loss_count), 32'd0);
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        relock();
        check("run_ready", 32'(ready), 32'd1);
        check("run_ce_first", 32'(ce), 32'b111);
        check("run_cnt", 32'(lock_loss_count), 32'd0);

        for (int t = 1; t <= 62; t++) begin
            tick();
            check("ce_div", 32'(ce), 32'({t % 7 == 0, t % 50 == 0, t % 5 == 0}));
        end

        div_sel = 2'd0;
        div_val = 16'd3;
        for (int t = 63; t <= 74; t++) begin
            div_wr = (t == 63);
            tick();
            check("ce_ratio3", 32'(ce[0]),
                  32'(t == 65 || t == 68 || t == 71 || t == 74));
        end

        div_val = 16'd0;
        for (int t = 75; t <= 86; t++) begin
            div_wr = (t == 75);
            tick();
            check("ce_ratio0", 32'(ce[0]), 32'(t >= 77));
        end

        div_sel = 2'd3;
        div_val = 16'd2;
        for (int t = 87; t <= 110; t++) begin
            div_wr = (t == 87);
            tick();
            check("ce_oor", 32'(ce), 32'({t % 7 == 0, t % 50 == 0, 1'b1}));
        end
        div_wr = 1'b0;

        locked_in = 1'b0;
        repeat (3) tick();
        check("drop_rst_early", 32'(rst_out_n), 32'd1);
        tick();
        check("drop_rst", 32'(rst_out_n), 32'd0);
        check("drop_ready", 32'(ready), 32'd0);
        check("drop_ce", 32'(ce), 32'd0);
        check("drop_cnt", 32'(lock_loss_count), 32'd1);

        relock();
        check("persist_ce0", 32'(ce), 32'b111);
        for (int t = 1; t <= 3; t++) begin
            tick();
            check("persist_ce", 32'(ce), 32'b001);
        end
        drop_lock();
        check("cnt_two", 32'(lock_loss_count), 32'd2);

        repeat (298) begin
            relock();
            drop_lock();
        end
        check("cnt_sat", 32'(lock_loss_count), 32'd255);

        relock();
        locked_in = 1'b0;
        repeat (2) tick();
        lock_loss_clr = 1'b1;
        tick();
        lock_loss_clr = 1'b0;
        check("clr_coinc", 32'(lock_loss_count), 32'd1);
        tick();
        lock_loss_clr = 1'b1;
        tick();
        lock_loss_clr = 1'b0;
        check("clr_alone", 32'(lock_loss_count), 32'd0);

        relock();
        drop_lock();
        check("cnt_pre_hold", 32'(lock_loss_count), 32'd1);
        locked_in = 1'b1;
        repeat (12) tick();
        check("hold_rst", 32'(rst_out_n), 32'd0);
        resetn    = 1'b0;
        locked_in = 1'b0;
        #2;
        check("hold_arst_cnt", 32'(lock_loss_count), 32'd0);
        check("hold_arst_rst", 32'(rst_out_n), 32'd0);
        check("hold_arst_ce", 32'(ce), 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        div_sel = 2'd0;
        div_val = 16'd2;
        div_wr  = 1'b1;
        tick();
        div_wr = 1'b0;
        relock();
        for (int t = 1; t <= 4; t++) begin
            tick();
            check("ce_idle_wr", 32'(ce[0]), 32'(t % 2 == 0));
        end
        resetn    = 1'b0;
        locked_in = 1'b0;
        #2;
        check("run_arst_rst", 32'(rst_out_n), 32'd0);
        check("run_arst_ready", 32'(ready), 32'd0);
        check("run_arst_ce", 32'(ce), 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        locked_in = 1'b1;
        repeat (5) tick();
        locked_in = 1'b0;
        tick();
        locked_in = 1'b1;
        repeat (15) tick();
        check("glitch_early", 32'(rst_out_n), 32'd0);
        tick();
        check("glitch_rst", 32'(rst_out_n), 32'd1);
        check("glitch_cnt", 32'(lock_loss_count), 32'd0);
        for (int t = 1; t <= 6; t++) begin
            tick();
            check("ce_revert", 32'(ce[0]), 32'(t % 5 == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
